alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning operand/result width in bits; legal values are even and at least 4.
REQ-002 The block SHALL have parameter MUL_W, fixed at WIDTH/2, meaning the multiplier operand width in bits; it SHALL not be overridden.
REQ-003 One clock and one asynchronous active-low reset are already decided; port list, clock and reset first:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- aluop  in  4  operation code.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- s  out  WIDTH  result.
- iszero  out  1  high when s is all zeros.
- ovf  out  1  signed overflow of ADD/SUB.

Function
REQ-004 Op codes SHALL be:
- 0000 AND
- 0001 OR
- 0010 ADD (a+b)
- 0110 SUB (a-b)
- 0111 SLT (s=1 if signed a<b, else 0)
- 1100 NOR
- 1000 MUL (unsigned a[MUL_W-1:0] * b[MUL_W-1:0], full WIDTH product)
REQ-005 Any other aluop SHALL be accepted as a single-cycle op giving s=0, ovf=0.
REQ-006 A request SHALL be accepted on a rising edge where in_valid and in_ready are both 1; a, b and aluop SHALL be captured at that edge only.
REQ-007 in_ready SHALL equal (state==IDLE) and (out_valid==0 or out_ready==1).
REQ-008 The FSM SHALL have states IDLE and MUL_BUSY; the result holding register is separate and qualified by out_valid.
REQ-009 A non-MUL op accepted at edge k SHALL have out_valid=1 and a valid s after edge k (latency 1); the FSM SHALL stay in IDLE.
REQ-010 On acceptance, MUL SHALL move IDLE->MUL_BUSY, clear the accumulator and load a step counter.
- Each edge in MUL_BUSY SHALL process one multiplier bit, LSB first, by shift-add.
- After exactly MUL_W edges in MUL_BUSY the FSM SHALL return to IDLE with out_valid=1.
- Total latency SHALL be MUL_W+1 edges from the accepting edge (17 at WIDTH=32).
REQ-011 in_ready SHALL be 0 throughout MUL_BUSY; in_valid SHALL be ignored there.
REQ-012 Result transfer SHALL occur on an edge with out_valid=1 and out_ready=1.
- If no new result is produced at that edge, out_valid SHALL fall.
- If a single-cycle op is accepted at the same edge, out_valid SHALL stay 1 and s SHALL update (back-to-back throughput of 1 per cycle).
REQ-013 While out_valid=1 and out_ready=0, s, iszero and ovf SHALL hold stable and in_ready SHALL be 0.
REQ-014 ADD/SUB SHALL wrap modulo 2^WIDTH.
- ovf SHALL be 1 when operand signs (B sign inverted for SUB) agree and the result sign differs.
- ovf SHALL be 0 for all non-ADD/SUB ops.
REQ-015 SLT SHALL use the true signed comparison, correct even when a-b overflows.
REQ-016 iszero SHALL be the NOR of the registered s, valid whenever out_valid=1.
REQ-017 MUL SHALL ignore a[WIDTH-1:MUL_W] and b[WIDTH-1:MUL_W]; the product SHALL never overflow WIDTH.

Reset
REQ-018 On rst_n low, asynchronously: FSM=IDLE, step counter=0, accumulator=0, s=0, out_valid=0, ovf=0, iszero=1.
REQ-019 In-flight MUL progress SHALL be discarded and no result produced for it.
REQ-020 in_ready SHALL be 1 from the first edge after rst_n deasserts.

Verification
REQ-021 The bench SHALL cover these directed scenarios (WIDTH=32):
- ADD a=0x7FFFFFFF, b=1, out_ready=1 -> next edge out_valid=1, s=0x80000000, ovf=1, iszero=0.
- SUB a=5, b=5 -> s=0, iszero=1, ovf=0; SLT a=0x80000000, b=1 -> s=1.
- MUL a=0xFFFF_FFFF, b=0x1234_FFFF -> in_ready=0 for 16 edges, out_valid after edge 17, s=0xFFFE0001.
- Backpressure: out_ready=0 for 5 cycles after an AND result (a=0xF0F0F0F0, b=0xFF00FF00 -> s=0xF000F000) -> s stable, in_ready=0; release -> out_valid falls next edge.
- Back-to-back OR, NOR, ADD with in_valid=1 and out_ready=1 -> one result per cycle in order; undefined op 1111 -> s=0.
- rst_n low at MUL step 8 -> immediate out_valid=0, s=0; after release, new ADD 2+3 -> s=5 with latency 1.

Source files
------------

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith ops plus a shift-add multiplier
// that takes MUL_W cycles. Results sit in a valid/ready holding register.
module alu_seq #(
    parameter int WIDTH = 32,
    localparam int MUL_W = WIDTH / 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       aluop,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             iszero,
    output logic             ovf
);

    // state    | meaning
    // IDLE     | accepting requests; single-cycle ops complete here
    // MUL_BUSY | shift-add multiply in progress, one multiplier bit per edge
    typedef enum logic {
        IDLE     = 1'b0,
        MUL_BUSY = 1'b1
    } state_t;

    localparam int CNT_W = $clog2(MUL_W + 1);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_MUL = 4'b1000;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [MUL_W-1:0]   mplier_q, mplier_d;
    logic [WIDTH-1:0]   s_q, s_d;
    logic               ovf_q, ovf_d;
    logic               out_valid_q, out_valid_d;

    logic               accept;
    logic               is_mul;
    logic               mul_done;
    logic [WIDTH-1:0]   alu_s;
    logic               alu_ovf;
    logic [WIDTH-1:0]   sum;
    logic [WIDTH-1:0]   diff;
    logic [WIDTH-1:0]   acc_step;

    assign accept   = in_valid && in_ready;
    assign is_mul   = (aluop == OP_MUL);
    assign mul_done = (state_q == MUL_BUSY) && (cnt_q == CNT_W'(1));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept && is_mul) begin
                    state_d = MUL_BUSY;
                end
            end
            MUL_BUSY: begin
                if (mul_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
    end

    // ---------------- single-cycle ALU ----------------
    always_comb begin
        sum     = a + b;
        diff    = a - b;
        alu_s   = '0;
        alu_ovf = 1'b0;
        case (aluop)
            OP_AND: alu_s = a & b;
            OP_OR:  alu_s = a | b;
            OP_NOR: alu_s = ~(a | b);
            OP_ADD: begin
                alu_s   = sum;
                alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_s   = diff;
                alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            // direct signed compare, so a-b overflow cannot flip the answer
            OP_SLT: alu_s = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: begin
                alu_s   = '0;
                alu_ovf = 1'b0;
            end
        endcase
    end

    // ---------------- multiplier datapath and result register ----------------
    always_comb begin
        acc_step    = acc_q + (mplier_q[0] ? mcand_q : '0);

        cnt_d       = cnt_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        s_d         = s_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            if (is_mul) begin
                cnt_d    = CNT_W'(MUL_W);
                acc_d    = '0;
                mcand_d  = {{(WIDTH-MUL_W){1'b0}}, a[MUL_W-1:0]};
                mplier_d = b[MUL_W-1:0];
            end else begin
                s_d         = alu_s;
                ovf_d       = alu_ovf;
                out_valid_d = 1'b1;
            end
        end

        if (state_q == MUL_BUSY) begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CNT_W'(1);
            if (mul_done) begin
                s_d         = acc_step;
                ovf_d       = 1'b0;
                out_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            s_q         <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            s_q         <= s_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign s         = s_q;
    assign ovf       = ovf_q;
    assign out_valid = out_valid_q;
    assign iszero    = ~|s_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=32.
module tb_alu_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  aluop;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] s;
    logic        iszero;
    logic        ovf;

    int n_checks;
    int n_pass;

    alu_seq #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .aluop     (aluop),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .iszero    (iszero),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // advance past the next rising edge; inputs change and outputs are sampled here
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] va, input logic [31:0] vb);
        aluop    = op;
        a        = va;
        b        = vb;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        aluop     = 4'b0000;
        out_ready = 1'b1;

        // reset state
        #12;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_s", s, 32'd0);
        chk("rst_iszero", {31'd0, iszero}, 32'd1);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        rst_n = 1'b1;
        step();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // ADD signed overflow
        issue(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001);
        chk("add_valid", {31'd0, out_valid}, 32'd1);
        chk("add_s", s, 32'h8000_0000);
        chk("add_ovf", {31'd0, ovf}, 32'd1);
        chk("add_iszero", {31'd0, iszero}, 32'd0);
        step();
        chk("add_valid_drop", {31'd0, out_valid}, 32'd0);

        // SUB to zero, SUB overflow, SLT cases
        issue(4'b0110, 32'd5, 32'd5);
        chk("sub_s", s, 32'd0);
        chk("sub_iszero", {31'd0, iszero}, 32'd1);
        chk("sub_ovf", {31'd0, ovf}, 32'd0);
        issue(4'b0110, 32'h8000_0000, 32'd1);
        chk("sub_ovf_s", s, 32'h7FFF_FFFF);
        chk("sub_ovf_flag", {31'd0, ovf}, 32'd1);
        issue(4'b0111, 32'h8000_0000, 32'd1);
        chk("slt_neg_s", s, 32'd1);
        chk("slt_neg_ovf", {31'd0, ovf}, 32'd0);
        issue(4'b0111, 32'h7FFF_FFFF, 32'h8000_0000);
        chk("slt_pos_s", s, 32'd0);
        step();

        // MUL: busy for 16 edges, result after the 16th busy edge
        issue(4'b1000, 32'hFFFF_FFFF, 32'h1234_FFFF);
        for (int i = 0; i < 16; i++) begin
            chk("mul_busy_ready", {31'd0, in_ready}, 32'd0);
            chk("mul_busy_valid", {31'd0, out_valid}, 32'd0);
            step();
        end
        chk("mul_valid", {31'd0, out_valid}, 32'd1);
        chk("mul_s", s, 32'hFFFE_0001);
        chk("mul_ovf", {31'd0, ovf}, 32'd0);
        step();
        chk("mul_valid_drop", {31'd0, out_valid}, 32'd0);

        // backpressure on an AND result; a pending request must be ignored
        out_ready = 1'b0;
        issue(4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00);
        chk("bp_s", s, 32'hF000_F000);
        aluop    = 4'b0010;
        a        = 32'd1;
        b        = 32'd1;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_hold_s", s, 32'hF000_F000);
            chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("bp_release_valid", {31'd0, out_valid}, 32'd0);

        // back-to-back single-cycle ops, one per edge
        aluop = 4'b0001; a = 32'h0F0F_0000; b = 32'h00F0_F0F0; in_valid = 1'b1;
        step();
        chk("b2b_or", s, 32'h0FFF_F0F0);
        chk("b2b_or_ready", {31'd0, in_ready}, 32'd1);
        aluop = 4'b1100; a = 32'h1234_0000; b = 32'h0000_5678;
        step();
        chk("b2b_nor", s, 32'hEDCB_A987);
        chk("b2b_nor_valid", {31'd0, out_valid}, 32'd1);
        aluop = 4'b0010; a = 32'h10; b = 32'h20;
        step();
        chk("b2b_add", s, 32'h30);
        aluop = 4'b1111; a = 32'd5; b = 32'd3;
        step();
        chk("undef_s", s, 32'd0);
        chk("undef_iszero", {31'd0, iszero}, 32'd1);
        chk("undef_valid", {31'd0, out_valid}, 32'd1);
        in_valid = 1'b0;
        step();
        chk("b2b_end_valid", {31'd0, out_valid}, 32'd0);

        // reset in the middle of a multiply
        issue(4'b0010, 32'd1, 32'd1);
        chk("pre_mul_s", s, 32'd2);
        issue(4'b1000, 32'd3, 32'd4);
        for (int i = 0; i < 7; i++) step();
        chk("mid_mul_ready", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_s", s, 32'd0);
        chk("mid_rst_iszero", {31'd0, iszero}, 32'd1);
        #2;
        rst_n = 1'b1;
        step();
        chk("post_rst_ready", {31'd0, in_ready}, 32'd1);
        chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
        for (int i = 0; i < 18; i++) begin
            step();
            chk("no_stale_mul", {31'd0, out_valid}, 32'd0);
        end
        issue(4'b0010, 32'd2, 32'd3);
        chk("post_rst_add_valid", {31'd0, out_valid}, 32'd1);
        chk("post_rst_add_s", s, 32'd5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
